mem_arbiter: RTL

//  Shares the single write port and data read port (raddr1/rdata1) of the

---
 rtl/mem_arbiter_if.sv | 18 +
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for mem_arbiter: one instance per master (m0, m1).
// master = requester view, slave = arbiter view.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          gnt;

    modport master (output req, we, lock, addr, wdata, input rdata, ack, gnt);
    modport slave  (input req, we, lock, addr, wdata, output rdata, ack, gnt);
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared memory write port and data read port.
// MEM_ARB_RR_EN defined selects round-robin; undefined selects fixed priority (m0 first).
//
// state  | meaning
// IDLE   | no access in flight; pick a winner when any req is high
// ACCESS | drive memory with owner's request; capture read data on exit
// RESP   | pulse owner ack; update lock tracking on exit
module mem_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MEM_WORDS = 32768,
    parameter int MAX_LOCK  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [AW:0] ADDR_LIM = (AW+1)'(MEM_WORDS);
    localparam logic [3:0]  LOCK_MAX = 4'(MAX_LOCK);

    state_t        state;
    state_t        state_nxt;
    logic          owner;
    logic          lock_own;
    logic          lock_valid;
    logic [3:0]    lock_cnt;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          winner;
    logic          any_req;
    logic          lock_hit;
    logic          in_range;
    logic          own_we;
    logic          own_lock;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
`ifdef MEM_ARB_RR_EN
    logic          last;
`endif

    always_comb begin
        own_we    = owner ? m1.we    : m0.we;
        own_lock  = owner ? m1.lock  : m0.lock;
        own_addr  = owner ? m1.addr  : m0.addr;
        own_wdata = owner ? m1.wdata : m0.wdata;
    end

    assign in_range = {1'b0, own_addr} < ADDR_LIM;
    assign any_req  = m0.req | m1.req;
    assign lock_hit = lock_valid && (lock_own ? m1.req : m0.req) && (lock_cnt < LOCK_MAX);

    // Lock rule has precedence; the policy only decides when it does not apply.
    always_comb begin
        if (lock_hit)
            winner = lock_own;
`ifdef MEM_ARB_RR_EN
        else if (m0.req && m1.req)
            winner = ~last;
`else
        else if (m0.req)
            winner = 1'b0;
`endif
        else
            winner = m1.req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        m0.ack    = 1'b0;
        m1.ack    = 1'b0;
        m0.gnt    = 1'b0;
        m1.gnt    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt = RESP;
                mem_raddr = own_addr;
                mem_waddr = own_addr;
                mem_wdata = own_wdata;
                mem_wen   = own_we & in_range;
                m0.gnt    = ~owner;
                m1.gnt    = owner;
            end
            RESP: begin
                state_nxt = IDLE;
                m0.ack    = ~owner;
                m1.ack    = owner;
                m0.gnt    = ~owner;
                m1.gnt    = owner;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m0.rdata = rdata0;
    assign m1.rdata = rdata1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            lock_own   <= 1'b0;
            lock_valid <= 1'b0;
            lock_cnt   <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
`ifdef MEM_ARB_RR_EN
            last       <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= winner;
`ifdef MEM_ARB_RR_EN
                        last  <= winner;
`endif
                        // The lock holder lost arbitration: its lock is gone.
                        if (lock_valid && (winner != lock_own)) begin
                            lock_valid <= 1'b0;
                            lock_cnt   <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (owner)
                        rdata1 <= in_range ? mem_rdata : '0;
                    else
                        rdata0 <= in_range ? mem_rdata : '0;
                end
                RESP: begin
                    if (own_lock) begin
                        lock_own   <= owner;
                        lock_valid <= 1'b1;
                        if (lock_valid && (lock_own == owner)) begin
                            if (lock_cnt < LOCK_MAX)
                                lock_cnt <= lock_cnt + 4'd1;
                        end else begin
                            lock_cnt <= 4'd1;
                        end
                    end else begin
                        lock_valid <= 1'b0;
                        lock_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
